cnu_row_merge: RTL and testbench
================================

CNU_ROW_MERGE -- requirements
Module: cnu_row_merge

Interface
REQ-001 Parameter data_w, default 9: unsigned magnitude width of every min value.
REQ-002 Parameter max_grp, default 8: max beats (3-edge groups) per check row; legal range 2..16.
REQ-003 Parameter grp_w, default 3: beat counter width; max_grp SHALL be <= 2**grp_w.
REQ-004 Derived pos_w = grp_w+2: edge position width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_min  input  2*data_w  group minima {smallest[2*data_w-1:data_w], second[data_w-1:0]}, pre-sorted upstream.
REQ-010 in_idx  input  3  one-hot local position (bit k = edge k of group) of smallest.
REQ-011 in_sgn  input  3  sign bits of the group's three edges.
REQ-012 in_last  input  1  final beat of current row.
REQ-013 out_valid  output  1  compressed row result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_min1, out_min2  output  data_w each  row smallest and second-smallest magnitude.
REQ-016 out_pos  output  pos_w  edge index of out_min1 = beat*3 + local.
REQ-017 out_sgn  output  1  XOR of all edge signs in row.
REQ-018 out_err  output  1  row force-terminated by overflow.

Function
REQ-019 Beat accepted ("fire") when in_valid && in_ready; in_ready SHALL = !out_valid || out_ready (combinational).
REQ-020 State machine, two states: EMPTY (no beat of current row held), ACC (>=1 beat held); reset -> EMPTY.
REQ-021 EMPTY + fire: acc_min1/acc_min2 load in_min halves, acc_pos = local idx, acc_sgn = ^in_sgn, beat_cnt = 1; -> ACC unless row completes.
REQ-022 ACC + fire: new min1 = in smallest if strictly < acc_min1, else acc_min1; new min2 = second smallest of {acc_min1, acc_min2, in smallest, in second}, ties resolved to accumulator values first; acc_pos updates only when min1 replaced, to beat_cnt*3 + local; acc_sgn ^= ^in_sgn; beat_cnt += 1.
REQ-023 Local position decode: lowest set bit of in_idx (001->0, 010->1, 100->2); in_idx = 000 decodes to 0.
REQ-024 Row completes on the fire with in_last=1, or the fire that makes beat_cnt reach max_grp (in_last=0 -> out_err=1 for that row); state -> EMPTY.
REQ-025 On completion the merged result (including that beat) SHALL load output registers and assert out_valid the next cycle; latency last-beat fire -> out_valid = 1 cycle.
REQ-026 Single-beat row (EMPTY fire with in_last=1) SHALL output that beat's values directly.
REQ-027 out_valid high with out_ready low: all out_* SHALL hold stable, in_ready = 0.
REQ-028 out_valid && out_ready same cycle as a completing fire: new result replaces old, out_valid stays 1; without completing fire, out_valid clears.
REQ-029 Back-to-back rows SHALL sustain one beat per cycle when out_ready = 1.
REQ-030 All comparisons unsigned data_w; no saturation or offset applied.

Reset
REQ-031 rst_n = 0 at a rising edge: state EMPTY, beat_cnt = 0, accumulators = 0, out_valid = 0, out_min1 = out_min2 = 0, out_pos = 0, out_sgn = 0, out_err = 0.
REQ-032 Reset mid-row or with a pending result SHALL discard both; first beat after reset starts a new row.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 Beat0 min=(5,9) idx=010 sgn=000; beat1 min=(3,7) idx=100 sgn=001 last -> out_min1=3, out_min2=5, out_pos=5, out_sgn=1, out_err=0, one cycle after beat1.
REQ-035 Tie: beat0 (4,6) idx=001; beat1 (4,4) idx=010 last -> out_min1=4, out_min2=4, out_pos=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles after result -> out_* stable, in_ready=0; out_ready=1 -> handshake, next row accepted same cycle.
REQ-037 Overflow: max_grp=8, 8 beats all in_last=0, beat3 (1,2) idx=100 minimum -> result after beat 8, out_pos=11, out_err=1.
REQ-038 Reset asserted after 2 of 4 beats -> out_valid=0; fresh 2-beat row then produces only its own values.
REQ-039 Streaming: 3-beat rows back-to-back, out_ready=1, random data vs reference model -> one result per 3 cycles, zero mismatches.

Source files
------------

// File: rtl/cnu_row_merge_if.sv
// Row-merge bus: beat stream in (group minima) and compressed row result out.
interface cnu_row_merge_if #(
  parameter int data_w = 9,
  parameter int grp_w  = 3
);
  localparam int pos_w = grp_w + 2;

  // valid/ready: a transfer happens on a rising edge where both are high;
  // the source holds its payload stable while valid is high and ready is low.
  logic                  in_valid;
  logic                  in_ready;
  logic [2*data_w-1:0]   in_min;
  logic [2:0]            in_idx;
  logic [2:0]            in_sgn;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_w-1:0]     out_min1;
  logic [data_w-1:0]     out_min2;
  logic [pos_w-1:0]      out_pos;
  logic                  out_sgn;
  logic                  out_err;

  modport master (
    output in_valid, in_min, in_idx, in_sgn, in_last, out_ready,
    input  in_ready, out_valid, out_min1, out_min2, out_pos, out_sgn, out_err
  );

  modport slave (
    input  in_valid, in_min, in_idx, in_sgn, in_last, out_ready,
    output in_ready, out_valid, out_min1, out_min2, out_pos, out_sgn, out_err
  );
endinterface

// File: rtl/cnu_row_merge.sv
// Check-node row merge: folds per-group (min1, min2, idx, signs) beats into one
// compressed row result (min1, min2, position, sign parity, overflow flag).
module cnu_row_merge #(
  parameter int data_w  = 9,
  parameter int max_grp = 8,
  parameter int grp_w   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cnu_row_merge_if.slave       bus,
  output logic                 dbg_state
);
  localparam int pos_w = grp_w + 2;
  localparam int cnt_w = grp_w + 1;

  typedef enum logic {EMPTY = 1'b0, ACC = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [data_w-1:0] acc_min1, acc_min2;
  logic [pos_w-1:0]  acc_pos;
  logic              acc_sgn;
  logic [cnt_w-1:0]  beat_cnt;

  logic [data_w-1:0] in_s1, in_s2, nxt_min1, nxt_min2;
  logic [pos_w-1:0]  nxt_pos, cnt_ext;
  logic              nxt_sgn, replace, fire, complete;
  logic [cnt_w-1:0]  nxt_cnt;
  logic [1:0]        local_idx;

  assign in_s1     = bus.in_min[2*data_w-1:data_w];
  assign in_s2     = bus.in_min[data_w-1:0];
  assign cnt_ext   = pos_w'(beat_cnt);
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign fire      = bus.in_valid && bus.in_ready;
  assign dbg_state = (state_q == ACC);

  always_comb begin
    local_idx = 2'd0;
    if (bus.in_idx[0])      local_idx = 2'd0;
    else if (bus.in_idx[1]) local_idx = 2'd1;
    else if (bus.in_idx[2]) local_idx = 2'd2;
  end

  // Both pairs arrive sorted, so the second-smallest of the four reduces to one compare.
  always_comb begin
    replace  = 1'b0;
    nxt_min1 = in_s1;
    nxt_min2 = in_s2;
    nxt_pos  = pos_w'(local_idx);
    nxt_sgn  = ^bus.in_sgn;
    nxt_cnt  = cnt_w'(1);
    if (state_q == ACC) begin
      replace = (in_s1 < acc_min1);
      nxt_sgn = acc_sgn ^ (^bus.in_sgn);
      nxt_cnt = beat_cnt + 1'b1;
      if (replace) begin
        nxt_min1 = in_s1;
        nxt_min2 = (acc_min1 <= in_s2) ? acc_min1 : in_s2;
        nxt_pos  = (cnt_ext << 1) + cnt_ext + pos_w'(local_idx);
      end else begin
        nxt_min1 = acc_min1;
        nxt_min2 = (acc_min2 <= in_s1) ? acc_min2 : in_s1;
        nxt_pos  = acc_pos;
      end
    end
  end

  assign complete = fire && (bus.in_last || (nxt_cnt == cnt_w'(max_grp)));

  always_comb begin
    state_d = state_q;
    if (fire) state_d = complete ? EMPTY : ACC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_min1      <= '0;
      acc_min2      <= '0;
      acc_pos       <= '0;
      acc_sgn       <= 1'b0;
      beat_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_min1  <= '0;
      bus.out_min2  <= '0;
      bus.out_pos   <= '0;
      bus.out_sgn   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      if (fire) begin
        acc_min1 <= nxt_min1;
        acc_min2 <= nxt_min2;
        acc_pos  <= nxt_pos;
        acc_sgn  <= nxt_sgn;
        beat_cnt <= complete ? '0 : nxt_cnt;
      end
      // A completing beat can only fire when the old result is gone or leaving now.
      if (complete) begin
        bus.out_valid <= 1'b1;
        bus.out_min1  <= nxt_min1;
        bus.out_min2  <= nxt_min2;
        bus.out_pos   <= nxt_pos;
        bus.out_sgn   <= nxt_sgn;
        bus.out_err   <= !bus.in_last;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cnu_row_merge.sv
// Directed bench for cnu_row_merge: reset, merge, ties, backpressure, overflow,
// mid-row reset and a short randomized streaming run against a sorting model.
module tb_cnu_row_merge;
  localparam int data_w = 9;
  localparam int grp_w  = 3;
  localparam int pos_w  = grp_w + 2;
  localparam int W      = 2*data_w + pos_w + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] exp_q[$];

  cnu_row_merge_if #(.data_w(data_w), .grp_w(grp_w)) bus ();

  cnu_row_merge #(.data_w(data_w), .max_grp(8), .grp_w(grp_w)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [data_w-1:0] s1, input logic [data_w-1:0] s2,
                      input logic [2:0] idx, input logic [2:0] sgn, input logic last);
    bus.in_valid = 1'b1;
    bus.in_min   = {s1, s2};
    bus.in_idx   = idx;
    bus.in_sgn   = sgn;
    bus.in_last  = last;
    #1 chk("in_ready_at_beat", 32'(bus.in_ready), 1);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int m1, input int m2, input int pos,
                         input int sgn, input int err);
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_min1"},  32'(bus.out_min1), 32'(m1));
    chk({tag, "_min2"},  32'(bus.out_min2), 32'(m2));
    chk({tag, "_pos"},   32'(bus.out_pos),  32'(pos));
    chk({tag, "_sgn"},   32'(bus.out_sgn),  32'(sgn));
    chk({tag, "_err"},   32'(bus.out_err),  32'(err));
  endtask

  initial begin
    logic [data_w-1:0] s1 [3];
    logic [data_w-1:0] s2 [3];
    logic [2:0]        sg [3];
    int                loc [3];
    logic [data_w-1:0] vals [6];
    logic [W-1:0]      exp_v;
    int                m1, m2, p, mi, par;

    bus.in_valid  = 1'b0;
    bus.in_min    = '0;
    bus.in_idx    = '0;
    bus.in_sgn    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_min1",  32'(bus.out_min1), 0);
    chk("rst_min2",  32'(bus.out_min2), 0);
    chk("rst_pos",   32'(bus.out_pos), 0);
    chk("rst_sgn",   32'(bus.out_sgn), 0);
    chk("rst_err",   32'(bus.out_err), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    #1 chk("rdy_after_rst", 32'(bus.in_ready), 1);

    // Basic two-beat row
    beat(9'd5, 9'd9, 3'b010, 3'b000, 1'b0);
    chk("b2_mid_valid", 32'(bus.out_valid), 0);
    chk("b2_mid_state", 32'(dbg_state), 1);
    beat(9'd3, 9'd7, 3'b100, 3'b001, 1'b1);
    idle();
    chk_out("basic", 3, 5, 5, 1, 0);
    chk("basic_state", 32'(dbg_state), 0);
    @(negedge clk);
    chk("basic_drain", 32'(bus.out_valid), 0);

    // Tie keeps accumulator minimum and its position
    beat(9'd4, 9'd6, 3'b001, 3'b000, 1'b0);
    beat(9'd4, 9'd4, 3'b010, 3'b011, 1'b1);
    idle();
    chk_out("tie", 4, 4, 0, 0, 0);
    @(negedge clk);

    // Backpressure: single-beat row held for 5 cycles
    bus.out_ready = 1'b0;
    beat(9'd8, 9'd10, 3'b100, 3'b111, 1'b1);
    idle();
    for (int i = 0; i < 5; i++) begin
      chk_out("hold", 8, 10, 2, 1, 0);
      chk("hold_rdy", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    beat(9'd7, 9'd12, 3'b001, 3'b001, 1'b0);
    chk("release_valid", 32'(bus.out_valid), 0);
    chk("release_state", 32'(dbg_state), 1);
    beat(9'd9, 9'd11, 3'b010, 3'b000, 1'b1);
    chk_out("after_bp", 7, 9, 0, 1, 0);
    // Completing fire while the previous result drains replaces it
    beat(9'd6, 9'd20, 3'b100, 3'b010, 1'b1);
    idle();
    chk_out("replace", 6, 20, 2, 1, 0);
    @(negedge clk);
    chk("replace_drain", 32'(bus.out_valid), 0);

    // Overflow: 8 beats without in_last
    for (int i = 0; i < 8; i++) begin
      if (i == 3) beat(9'd1, 9'd2, 3'b100, 3'b001, 1'b0);
      else        beat(9'(20 + i), 9'(30 + i), 3'b001, 3'b001, 1'b0);
      if (i == 6) chk("ovf_early_valid", 32'(bus.out_valid), 0);
    end
    idle();
    chk_out("ovf", 1, 2, 11, 0, 1);
    chk("ovf_state", 32'(dbg_state), 0);
    @(negedge clk);

    // Reset in the middle of a row discards it
    beat(9'd10, 9'd11, 3'b001, 3'b000, 1'b0);
    beat(9'd12, 9'd13, 3'b001, 3'b000, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_state", 32'(dbg_state), 0);
    chk("midrst_rdy",   32'(bus.in_ready), 1);
    beat(9'd15, 9'd16, 3'b010, 3'b001, 1'b0);
    beat(9'd14, 9'd18, 3'b001, 3'b000, 1'b1);
    idle();
    chk_out("post_rst", 14, 15, 3, 1, 0);
    @(negedge clk);

    // Streaming 3-beat rows, scoreboard against a sort-based model
    for (int r = 0; r < 6; r++) begin
      par = 0;
      for (int j = 0; j < 3; j++) begin
        s1[j]  = 9'($urandom_range(0, 511));
        s2[j]  = 9'($urandom_range(32'(s1[j]), 511));
        sg[j]  = 3'($urandom_range(0, 7));
        loc[j] = $urandom_range(0, 2);
        vals[2*j]     = s1[j];
        vals[2*j + 1] = s2[j];
        par = par ^ int'(^sg[j]);
      end
      m1 = s1[0]; p = loc[0];
      for (int j = 1; j < 3; j++)
        if (int'(s1[j]) < m1) begin m1 = s1[j]; p = 3*j + loc[j]; end
      mi = 0;
      for (int k = 1; k < 6; k++) if (vals[k] < vals[mi]) mi = k;
      m2 = 1024;
      for (int k = 0; k < 6; k++) if (k != mi && int'(vals[k]) < m2) m2 = vals[k];
      exp_q.push_back({9'(m1), 9'(m2), 5'(p), 1'(par), 1'b0});
      for (int j = 0; j < 3; j++) begin
        beat(s1[j], s2[j], 3'b001 << loc[j], sg[j], j == 2);
        chk("stream_valid", 32'(bus.out_valid), (j == 2) ? 1 : 0);
        if (j == 2) begin
          exp_v = exp_q.pop_front();
          chk("stream_result",
              32'({bus.out_min1, bus.out_min2, bus.out_pos, bus.out_sgn, bus.out_err}),
              32'(exp_v));
        end
      end
    end
    idle();
    @(negedge clk);
    chk("stream_end_valid", 32'(bus.out_valid), 0);
    chk("stream_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
